// File: rtl/pkt_gen_task_executor.sv
// Packet-generator task executor: turns {flow, size} tasks into a 64-bit packet stream.
// Optional per-flow packet counters enabled by PKT_GEN_TASK_EXECUTOR_STATS_EN.
module pkt_gen_task_executor #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int MIN_PKT_SIZE   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_i,
  input  logic [15:0]               task_pkt_size_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output logic [63:0]               pkt_data_o,
  output logic                      pkt_valid_o,
  output logic                      pkt_sop_o,
  output logic                      pkt_eop_o,
  output logic [2:0]                pkt_empty_o,
  input  logic                      pkt_ready_i,
  input  logic [FLOW_CNT_WIDTH-1:0] stat_rd_addr_i,
  output logic [31:0]               stat_rd_data_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                    state_q, state_d;
  logic [FLOW_CNT_WIDTH-1:0] flow_q, flow_d;
  logic [15:0]               size_q, size_d;
  logic [31:0]               seq_q, seq_d;
  logic [12:0]               idx_q, idx_d;
  logic [12:0]               last_q, last_d;
  logic [31:0]               seq_mem_q [FLOW_CNT];

  logic [15:0] eff_size;
  logic [12:0] eff_last;
  logic        send;
  logic        is_last;
  logic        accept;
  logic        eop_beat;

  assign eff_size = (task_pkt_size_i < 16'(MIN_PKT_SIZE))
                  ? 16'(MIN_PKT_SIZE) : task_pkt_size_i;
  // ceil(S/8)-1 == floor((S-1)/8), valid since S >= 8
  assign eff_last = 13'((eff_size - 16'd1) >> 3);

  assign send     = (state_q == SEND);
  assign is_last  = (idx_q == last_q);
  assign accept   = task_valid_i && task_ready_o;
  assign eop_beat = send && pkt_ready_i && is_last;

  always_comb begin
    state_d      = state_q;
    flow_d       = flow_q;
    size_d       = size_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    last_d       = last_q;
    task_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        task_ready_o = 1'b1;
      end
      SEND: begin
        if (pkt_ready_i) begin
          if (is_last) begin
            task_ready_o = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + 13'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a task taken on the final beat restarts SEND with no bubble
    if (task_valid_i && task_ready_o) begin
      state_d = SEND;
      flow_d  = task_flow_num_i;
      size_d  = eff_size;
      seq_d   = seq_mem_q[task_flow_num_i];
      idx_d   = 13'd0;
      last_d  = eff_last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      flow_q  <= '0;
      size_q  <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
      size_q  <= size_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        seq_mem_q[i] <= '0;
      end
    end else if (accept) begin
      seq_mem_q[task_flow_num_i] <= seq_mem_q[task_flow_num_i] + 32'd1;
    end
  end

  assign pkt_valid_o = send;
  assign pkt_sop_o   = send && (idx_q == 13'd0);
  assign pkt_eop_o   = send && is_last;
  assign pkt_empty_o = pkt_eop_o ? 3'(4'd8 - {1'b0, size_q[2:0]}) : 3'd0;

  always_comb begin
    pkt_data_o = '0;
    if (send) begin
      if (idx_q == 13'd0) begin
        pkt_data_o = {{(16-FLOW_CNT_WIDTH){1'b0}}, flow_q, seq_q, size_q};
      end else begin
        // byte offset in packet is {idx,j}; its low byte is the pattern
        for (int j = 0; j < 8; j++) begin
          if ({idx_q, 3'(j)} < size_q) begin
            pkt_data_o[63-8*j -: 8] = {idx_q[4:0], 3'(j)};
          end
        end
      end
    end
  end

`ifdef PKT_GEN_TASK_EXECUTOR_STATS_EN
  logic [31:0] cnt_q [FLOW_CNT];
  logic [31:0] stat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      stat_q <= '0;
    end else begin
      stat_q <= cnt_q[stat_rd_addr_i];
      if (eop_beat) begin
        cnt_q[flow_q] <= cnt_q[flow_q] + 32'd1;
      end
    end
  end

  assign stat_rd_data_o = stat_q;
`else
  logic unused_stat;
  assign unused_stat    = ^{stat_rd_addr_i, eop_beat};
  assign stat_rd_data_o = '0;
`endif

endmodule

// File: tb/tb_pkt_gen_task_executor.sv
// Bench for pkt_gen_task_executor: directed cases plus random tasks
// checked against a packet-level reference model.
module tb_pkt_gen_task_executor;

  localparam int FLOW_CNT = 16;
  localparam int FW       = 4;
  localparam int MINSZ    = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [FW-1:0] task_flow_num_i = '0;
  logic [15:0]   task_pkt_size_i = '0;
  logic          task_valid_i = 1'b0;
  logic          task_ready_o;
  logic [63:0]   pkt_data_o;
  logic          pkt_valid_o;
  logic          pkt_sop_o;
  logic          pkt_eop_o;
  logic [2:0]    pkt_empty_o;
  logic          pkt_ready_i = 1'b1;
  logic [FW-1:0] stat_rd_addr_i = '0;
  logic [31:0]   stat_rd_data_o;

  pkt_gen_task_executor #(
    .FLOW_CNT    (FLOW_CNT),
    .MIN_PKT_SIZE(MINSZ)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .task_flow_num_i(task_flow_num_i),
    .task_pkt_size_i(task_pkt_size_i),
    .task_valid_i   (task_valid_i),
    .task_ready_o   (task_ready_o),
    .pkt_data_o     (pkt_data_o),
    .pkt_valid_o    (pkt_valid_o),
    .pkt_sop_o      (pkt_sop_o),
    .pkt_eop_o      (pkt_eop_o),
    .pkt_empty_o    (pkt_empty_o),
    .pkt_ready_i    (pkt_ready_i),
    .stat_rd_addr_i (stat_rd_addr_i),
    .stat_rd_data_o (stat_rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    int          flow;
    int unsigned seq;
    int          size;
  } task_t;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    int unsigned cyc;
  } beat_t;

  task_t       exq[$];
  beat_t       cap[$];
  int unsigned mseq[FLOW_CNT];
  int unsigned mstat[FLOW_CNT];
  int          beat_k = 0;
  int          npkt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rdy_rand = 1'b0;
  logic        stall_v = 1'b0;
  logic [63:0] s_data;
  logic [5:0]  s_ctl;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input task_t t, input int k);
    logic [63:0] w;
    w = '0;
    if (k == 0) begin
      w[63:48] = 16'(t.flow);
      w[47:16] = t.seq;
      w[15:0]  = 16'(t.size);
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (8 * k + j < t.size) w[63-8*j -: 8] = 8'((8 * k + j) % 256);
      end
    end
    return w;
  endfunction

  always @(posedge clk_i) begin
    #1;
    pkt_ready_i = rdy_rand ? 1'($urandom % 2) : 1'b1;
  end

  // monitor + reference model, sampled mid-cycle
  always @(negedge clk_i) begin
    if (rst_i) begin
      exq.delete();
      beat_k  = 0;
      stall_v = 1'b0;
      for (int f = 0; f < FLOW_CNT; f++) begin
        mseq[f]  = 0;
        mstat[f] = 0;
      end
    end else begin
      if (stall_v) begin
        chk("stall_data", pkt_data_o, s_data);
        chk("stall_ctl", 64'({pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_empty_o}),
            64'(s_ctl));
      end
      stall_v = pkt_valid_o && !pkt_ready_i;
      s_data  = pkt_data_o;
      s_ctl   = {pkt_valid_o, pkt_sop_o, pkt_eop_o, pkt_empty_o};
      if (pkt_valid_o && pkt_ready_i) begin
        cap.push_back('{pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_empty_o, cyc});
        if (exq.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          task_t t;
          int    w;
          t = exq[0];
          w = (t.size + 7) / 8;
          chk("data", pkt_data_o, exp_word(t, beat_k));
          chk("sop", 64'(pkt_sop_o), 64'(beat_k == 0));
          chk("eop", 64'(pkt_eop_o), 64'(beat_k == w - 1));
          chk("empty", 64'(pkt_empty_o),
              (beat_k == w - 1) ? 64'((8 - t.size % 8) % 8) : 64'd0);
          beat_k++;
          if (beat_k == w) begin
            void'(exq.pop_front());
            beat_k = 0;
            mstat[t.flow]++;
            npkt++;
          end
        end
      end
      if (task_valid_i && task_ready_o) begin
        task_t t;
        t.flow = int'(task_flow_num_i);
        t.size = (task_pkt_size_i < MINSZ) ? MINSZ : int'(task_pkt_size_i);
        t.seq  = mseq[t.flow];
        mseq[t.flow]++;
        exq.push_back(t);
      end
    end
  end

  task automatic send_task(input int flow, input int size);
    int t;
    t = 0;
    task_flow_num_i = FW'(flow);
    task_pkt_size_i = 16'(size);
    task_valid_i    = 1'b1;
    forever begin
      @(negedge clk_i);
      if (task_ready_o) break;
      t++;
      if (t > 20000) begin
        chk("task_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exq.size() != 0 && t < 40000) begin
      @(posedge clk_i);
      t++;
    end
    #1;
    if (exq.size() != 0) chk("drain_timeout", 64'(exq.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic check_stats(input string tag);
    logic [63:0] e;
    for (int f = 0; f < FLOW_CNT; f++) begin
      stat_rd_addr_i = FW'(f);
      @(posedge clk_i);
      #1;
`ifdef PKT_GEN_TASK_EXECUTOR_STATS_EN
      e = 64'(mstat[f]);
`else
      e = 64'd0;
`endif
      chk(tag, 64'(stat_rd_data_o), e);
    end
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_task_ready", 64'(task_ready_o), 64'd1);
    chk("rst_valid", 64'(pkt_valid_o), 64'd0);
    chk("rst_flags", 64'({pkt_sop_o, pkt_eop_o, pkt_empty_o}), 64'd0);
    chk("rst_data", pkt_data_o, 64'd0);
    chk("rst_stat", 64'(stat_rd_data_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    cap.delete();
    send_task(3, 64);
    task_valid_i = 1'b0;
    chk("t1_sop_latency", 64'({pkt_valid_o, pkt_sop_o}), 64'd3);
    drain();
    chk("t1_words", 64'(cap.size()), 64'd8);
    if (cap.size() == 8) begin
      chk("t1_sop", 64'(cap[0].sop), 64'd1);
      chk("t1_eop", 64'(cap[7].eop), 64'd1);
      chk("t1_empty", 64'(cap[7].empty), 64'd0);
      chk("t1_w0", cap[0].data, 64'h0003_0000_0000_0040);
      chk("t1_w1", cap[1].data, 64'h0809_0A0B_0C0D_0E0F);
    end

    cap.delete();
    send_task(0, 61);
    task_valid_i = 1'b0;
    drain();
    chk("t2_words", 64'(cap.size()), 64'd8);
    if (cap.size() == 8) begin
      chk("t2_eop", 64'(cap[7].eop), 64'd1);
      chk("t2_empty", 64'(cap[7].empty), 64'd3);
      chk("t2_w7", cap[7].data, 64'h3839_3A3B_3C00_0000);
    end

    cap.delete();
    send_task(5, 5);
    task_valid_i = 1'b0;
    drain();
    chk("t3_words", 64'(cap.size()), 64'd2);
    if (cap.size() == 2) begin
      chk("t3_size", 64'(cap[0].data[15:0]), 64'h10);
      chk("t3_empty", 64'(cap[1].empty), 64'd0);
    end

    cap.delete();
    send_task(2, 24);
    send_task(2, 24);
    send_task(2, 24);
    task_valid_i = 1'b0;
    drain();
    chk("t4_words", 64'(cap.size()), 64'd9);
    if (cap.size() == 9) begin
      chk("t4_no_bubble", 64'(cap[8].cyc - cap[0].cyc), 64'd8);
      chk("t4_seq0", 64'(cap[0].data[47:16]), 64'd0);
      chk("t4_seq1", 64'(cap[3].data[47:16]), 64'd1);
      chk("t4_seq2", 64'(cap[6].data[47:16]), 64'd2);
    end

    cap.delete();
    send_task(7, 65535);
    task_valid_i = 1'b0;
    drain();
    chk("t5_words", 64'(cap.size()), 64'd8192);
    if (cap.size() == 8192) chk("t5_empty", 64'(cap[8191].empty), 64'd1);

    base     = npkt;
    rdy_rand = 1'b1;
    for (int n = 0; n < 100; n++) begin
      int f;
      int sz;
      f = $urandom_range(0, FLOW_CNT - 1);
      case ($urandom % 4)
        0:       sz = $urandom_range(0, 16);
        1, 2:    sz = $urandom_range(17, 200);
        default: sz = $urandom_range(200, 1000);
      endcase
      send_task(f, sz);
      if ($urandom % 2 == 1) begin
        task_valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    task_valid_i = 1'b0;
    drain();
    rdy_rand = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rand_pkts", 64'(npkt - base), 64'd100);
    check_stats("rand_stat");

    cap.delete();
    send_task(1, 80);
    task_valid_i = 1'b0;
    t = 0;
    while (cap.size() < 3 && t < 100) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    chk("t7_pre_beats", 64'(cap.size()), 64'd3);
    chk("t7_word3", 64'(pkt_data_o[63:56]), 64'd24);
    chk("t7_no_eop", 64'(cap[0].eop | cap[1].eop | cap[2].eop), 64'd0);
    rst_i = 1'b1;
    #1;
    chk("t7_rst_valid", 64'({pkt_valid_o, pkt_eop_o}), 64'd0);
    chk("t7_rst_ready", 64'(task_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    cap.delete();
    send_task(1, 16);
    task_valid_i = 1'b0;
    drain();
    chk("t7_words", 64'(cap.size()), 64'd2);
    if (cap.size() == 2) begin
      chk("t7_hdr", cap[0].data, 64'h0001_0000_0000_0010);
      chk("t7_eop", 64'(cap[1].eop), 64'd1);
    end
    check_stats("t7_stat");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
